// File: rtl/logic_unit_pkg.sv
// Shared types and constants for the pipelined bitwise logic unit.
package logic_unit_pkg;

    localparam int MAX_WIDTH  = 64;
    localparam int MAX_STAGES = 4;

    typedef enum logic [2:0] {
        OP_AND   = 3'd0,
        OP_OR    = 3'd1,
        OP_XOR   = 3'd2,
        OP_XNOR  = 3'd3,
        OP_NAND  = 3'd4,
        OP_NOR   = 3'd5,
        OP_NOTA  = 3'd6,
        OP_PASSA = 3'd7
    } op_e;

    typedef struct packed {
        logic zero;
        logic all_ones;
        logic parity;
    } flags_t;

    // Zero-extension does not change parity, so one fixed-width helper serves every WIDTH.
    function automatic logic parity_of(input logic [MAX_WIDTH-1:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/logic_unit_stage.sv
// One valid/data register slice of the logic unit pipeline with ready/advance logic.
module logic_unit_stage
    import logic_unit_pkg::*;
#(
    parameter int DW = 19
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    logic          valid_r;
    logic [DW-1:0] data_r;

    // Slot can be refilled when empty or when its current beat moves on this cycle.
    assign in_ready  = !valid_r || out_ready;
    assign out_valid = valid_r;
    assign out_data  = data_r;

    // Slot register; data is only overwritten by a real beat so an empty slot keeps its last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
            data_r  <= '0;
        end else if (in_ready) begin
            valid_r <= in_valid;
            if (in_valid) begin
                data_r <= in_data;
            end else begin
                data_r <= data_r;
            end
        end else begin
            valid_r <= valid_r;
            data_r  <= data_r;
        end
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// Pipelined WIDTH-bit bitwise logic unit (8 ops) with valid/ready backpressure and result flags.
// Optional LOGIC_UNIT_STATS_EN adds a saturating result_count of output handshakes.
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             all_ones,
    output logic             parity
`ifdef LOGIC_UNIT_STATS_EN
    ,
    output logic [31:0]      result_count
`endif
);

    localparam int DW = WIDTH + 3;

    logic [WIDTH-1:0]     result_s;
    logic [MAX_WIDTH-1:0] result_ext_s;
    flags_t               flags_s;

    logic                 valid_s [0:STAGES];
    logic                 ready_s [0:STAGES];
    logic [DW-1:0]        data_s  [0:STAGES];

    // Operation decode on the raw inputs; flags are derived before capture so they travel with y.
    always_comb begin
        result_s     = '0;
        result_ext_s = '0;
        case (op_e'(op))
            OP_AND:   result_s = a & b;
            OP_OR:    result_s = a | b;
            OP_XOR:   result_s = a ^ b;
            OP_XNOR:  result_s = ~(a ^ b);
            OP_NAND:  result_s = ~(a & b);
            OP_NOR:   result_s = ~(a | b);
            OP_NOTA:  result_s = ~a;
            OP_PASSA: result_s = a;
            default:  result_s = a;
        endcase
        result_ext_s[WIDTH-1:0] = result_s;
        flags_s.zero            = (result_s == '0);
        flags_s.all_ones        = &result_s;
        flags_s.parity          = parity_of(result_ext_s);
    end

    assign valid_s[0]      = in_valid;
    assign data_s[0]       = {result_s, flags_s};
    assign ready_s[STAGES] = out_ready;
    assign in_ready        = ready_s[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic_unit_stage #(
            .DW(DW)
        ) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (valid_s[k]),
            .in_data  (data_s[k]),
            .in_ready (ready_s[k]),
            .out_valid(valid_s[k+1]),
            .out_ready(ready_s[k+1]),
            .out_data (data_s[k+1])
        );
    end

    assign out_valid = valid_s[STAGES];
    assign {y, zero, all_ones, parity} = data_s[STAGES];

`ifdef LOGIC_UNIT_STATS_EN
    logic [31:0] count_r;

    // Saturating count of delivered results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= 32'd0;
        end else if (out_valid && out_ready && (count_r != 32'hFFFF_FFFF)) begin
            count_r <= count_r + 32'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign result_count = count_r;
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed self-checking bench for logic_unit_pipe (default 16x2 plus a 1x1, 8x4, 64x4 sweep).
module tb_logic_unit_pipe;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, out_valid, out_ready, zero, all_ones, parity;
    logic [2:0]  op;
    logic [15:0] a, b, y;

    logic        sw_valid;
    logic [2:0]  sw_in_ready, sw_out_valid, sw_zero, sw_all, sw_par;
    logic [0:0]  y1;
    logic [7:0]  y8;
    logic [63:0] y64;

    int vectors     = 0;
    int miscompares = 0;
    int sent;
    logic [15:0] exp_ops [8];

`ifdef LOGIC_UNIT_STATS_EN
    logic [31:0] result_count, rc1, rc8, rc64;
`endif

    always #5 clk = ~clk;

    logic_unit_pipe #(.WIDTH(16), .STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .y(y), .zero(zero), .all_ones(all_ones),
        .parity(parity)
`ifdef LOGIC_UNIT_STATS_EN
        , .result_count(result_count)
`endif
    );

    logic_unit_pipe #(.WIDTH(1), .STAGES(1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(sw_in_ready[0]), .op(3'd5),
        .a(1'b0), .b(1'b0), .out_valid(sw_out_valid[0]), .out_ready(1'b1), .y(y1),
        .zero(sw_zero[0]), .all_ones(sw_all[0]), .parity(sw_par[0])
`ifdef LOGIC_UNIT_STATS_EN
        , .result_count(rc1)
`endif
    );

    logic_unit_pipe #(.WIDTH(8), .STAGES(4)) u_w8 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(sw_in_ready[1]), .op(3'd5),
        .a(8'h00), .b(8'h00), .out_valid(sw_out_valid[1]), .out_ready(1'b1), .y(y8),
        .zero(sw_zero[1]), .all_ones(sw_all[1]), .parity(sw_par[1])
`ifdef LOGIC_UNIT_STATS_EN
        , .result_count(rc8)
`endif
    );

    logic_unit_pipe #(.WIDTH(64), .STAGES(4)) u_w64 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(sw_in_ready[2]), .op(3'd5),
        .a(64'd0), .b(64'd0), .out_valid(sw_out_valid[2]), .out_ready(1'b1), .y(y64),
        .zero(sw_zero[2]), .all_ones(sw_all[2]), .parity(sw_par[2])
`ifdef LOGIC_UNIT_STATS_EN
        , .result_count(rc64)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_ops = '{16'h3030, 16'hFCFC, 16'hCCCC, 16'h3333, 16'hCFCF, 16'h0303, 16'h0F0F, 16'hF0F0};
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; op = 3'd0; a = 16'h0; b = 16'h0;
        sw_valid = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_y_flags", {y, zero, all_ones, parity}, 0);
        rst_n = 1'b1;
        step();
        chk("rst_in_ready", in_ready, 1);

        // XNOR basics and latency of 2
        in_valid = 1'b1; op = 3'd3; a = 16'hAAAA; b = 16'h5555;
        #1;
        chk("xnor_in_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        chk("xnor_lat1_out_valid", out_valid, 0);
        step();
        chk("xnor_lat2_out_valid", out_valid, 1);
        chk("xnor_y", y, 16'h0000);
        chk("xnor_flags", {zero, all_ones, parity}, 3'b100);
        in_valid = 1'b1; a = 16'h1234; b = 16'h4321;
        step();
        in_valid = 1'b0;
        step();
        chk("xnor2_y", y, 16'hAEEA);
        chk("xnor2_flags", {out_valid, zero, all_ones, parity}, 4'b1000);
        step();

        // All eight ops issued back to back: one result per cycle, in order
        a = 16'hF0F0; b = 16'h3C3C;
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) begin
                in_valid = 1'b1;
                op = 3'(i);
            end else begin
                in_valid = 1'b0;
            end
            step();
            if (i >= 1) begin
                chk($sformatf("ops_valid_%0d", i - 1), out_valid, 1);
                chk($sformatf("ops_y_%0d", i - 1), y, exp_ops[i-1]);
            end
        end
        step();
        chk("empty_out_valid", out_valid, 0);
        chk("empty_y_hold", y, 16'hF0F0);

        // Backpressure: two slots fill, third beat waits, then all drain in order
        out_ready = 1'b0; op = 3'd7; b = 16'h0;
        in_valid = 1'b1; a = 16'h0001;
        #1;
        chk("bp_ready1", in_ready, 1);
        step();
        a = 16'h0002;
        #1;
        chk("bp_ready2", in_ready, 1);
        step();
        a = 16'h0003;
        #1;
        chk("bp_full_ready", in_ready, 0);
        step();
        chk("bp_stall_y", {out_valid, y}, {1'b1, 16'h0001});
        step();
        chk("bp_stall_y_hold", {out_valid, in_ready, y}, {2'b10, 16'h0001});
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        chk("bp_out2", {out_valid, y}, {1'b1, 16'h0002});
        step();
        chk("bp_out3", {out_valid, y}, {1'b1, 16'h0003});
        step();
        chk("bp_drained", out_valid, 0);

        // Reset mid-stream discards in-flight beats
        out_ready = 1'b0; in_valid = 1'b1; a = 16'h0011;
        step();
        a = 16'h0022;
        step();
        in_valid = 1'b0;
        chk("mrst_inflight", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_out_valid", out_valid, 0);
        chk("mrst_y", y, 16'h0);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("mrst_no_stale_%0d", i), {out_valid, in_ready}, 2'b01);
        end

        // Parameter sweep: NOR of zeros gives all ones, latency equals STAGES
        sw_valid = 1'b1;
        #1;
        chk("sw_in_ready", sw_in_ready, 3'b111);
        step();
        sw_valid = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            chk($sformatf("sw_lat_c%0d", c), sw_out_valid, {c == 4, c == 4, c == 1});
            if (c == 1) begin
                chk("sw_w1", {y1, sw_zero[0], sw_all[0], sw_par[0]}, 4'b1011);
            end
            if (c == 4) begin
                chk("sw_w8", {y8, sw_zero[1], sw_all[1], sw_par[1]}, {8'hFF, 3'b010});
                chk("sw_w64_y", y64, 64'hFFFF_FFFF_FFFF_FFFF);
                chk("sw_w64_flags", {sw_zero[2], sw_all[2], sw_par[2]}, 3'b010);
            end
            step();
        end

`ifdef LOGIC_UNIT_STATS_EN
        // Counter: 10 handshakes under random stalls, then saturation
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        step();
        sent = 0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (sent >= 10 && !out_valid) break;
            in_valid  = (sent < 10);
            out_ready = 1'($urandom_range(0, 1));
            a = 16'(sent);
            #1;
            if (in_valid && in_ready) sent++;
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("stats_sent", sent, 10);
        chk("stats_count10", result_count, 32'd10);
        force dut.count_r = 32'hFFFF_FFFE;
        step();
        release dut.count_r;
        in_valid = 1'b1;
        repeat (3) step();
        in_valid = 1'b0;
        repeat (3) step();
        chk("stats_saturate", result_count, 32'hFFFF_FFFF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
Parametrised, pipelined bitwise logic unit for the ALU datapath. It generalises the fixed 16-bit single-function XNOR gate to WIDTH bits and eight selectable operations. Results pass through a STAGES-deep register pipeline with a valid/ready handshake and full backpressure. Result flags (zero, all-ones, parity) are registered alongside the data for the ALU status logic.

Parameters:
WIDTH, 16, operand/result width in bits (legal range 1..64)
STAGES, 2, pipeline depth = latency in cycles from input handshake to out_valid (legal range 1..4)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand/op beat valid
in_ready  out  1  unit can accept a beat this cycle
op  in  3  operation select
a  in  WIDTH  operand A
b  in  WIDTH  operand B
out_valid  out  1  result beat valid
out_ready  in  1  downstream accepts result
y  out  WIDTH  result
zero  out  1  y == 0
all_ones  out  1  y == all ones
parity  out  1  XOR-reduction of y (1 = odd number of ones)

Behaviour:
- Reset: one clock, asynchronous active-low; same clock and reset for all stages. Assertion immediately clears all stage valid bits. out_valid=0, y=0, zero=0, all_ones=0, parity=0 while rst_n=0. in_ready=1 from the first edge after deassertion.
- op encoding: 0 AND, 1 OR, 2 XOR, 3 XNOR, 4 NAND, 5 NOR, 6 NOT A (b ignored), 7 PASS A.
- Computation is combinational on a, b and op at the input. It is captured into stage 0 on an input handshake (in_valid & in_ready). Flags are computed from the result before capture and travel with it.
- Stage k (0..STAGES-1) holds {valid, y, flags}. Stage k advances when stage k+1 is empty or is itself advancing. The last stage advances on out_ready.
- in_ready = !stage0.valid | stage0 advancing. It is combinational from out_ready through the stage chain. There is no combinational path from in_valid to out_valid.
- Latency: a result accepted in cycle N appears with out_valid=1 in cycle N+STAGES when unstalled.
- Throughput is 1 beat/cycle with out_ready held high. Beats are never dropped, duplicated or reordered.
- Full: all STAGES slots valid and out_ready=0 -> in_ready=0. y and flags hold stable while out_valid=1 and out_ready=0.
- Simultaneous input and output handshake while full: both occur and occupancy is unchanged.
- Empty: out_valid=0; y and flags hold their last value (not cleared).
- Reset mid-operation: all in-flight beats are discarded and no partial output appears.
- Width rules: all ops are bitwise; there is no carry or sign. all_ones uses an AND-reduction over exactly WIDTH bits.

Optional Feature:
Macro LOGIC_UNIT_STATS_EN.
- Defined: adds output port result_count (32 bits). It counts output handshakes (out_valid & out_ready) and saturates at 32'hFFFF_FFFF. Reset value is 0.
- Not defined: the port and counter are absent. Behaviour is otherwise identical.

Decomposition:
- Package logic_unit_pkg holds:
  - the op enum typedef (OP_AND..OP_PASSA, 3 bits)
  - the flag struct typedef {zero, all_ones, parity}
  - constants MAX_WIDTH=64 and MAX_STAGES=4
- One sub-module, logic_unit_stage: a single valid/data register slice with advance logic, instantiated STAGES times via generate.

Test Plan:
- XNOR basics, WIDTH=16, STAGES=2: op=3, a=16'hAAAA, b=16'h5555 -> y=16'h0000, zero=1, all_ones=0, parity=0, exactly 2 cycles after acceptance. Then a=16'h1234, b=16'h4321 -> y=16'hAEEA, parity=0.
- All ops on a=16'hF0F0, b=16'h3C3C, out_ready=1:
  - AND->3030, OR->FCFC, XOR->CCCC, XNOR->3333
  - NAND->CFCF, NOR->0303, NOTA->0F0F, PASSA->F0F0
  - Back-to-back issue gives one result per cycle, in order.
- Backpressure, STAGES=2: out_ready=0, drive 3 beats -> in_ready=0 after 2 accepted, y stable. Raise out_ready -> third beat accepted the same cycle the first beat leaves; all 3 delivered in order.
- Reset mid-stream: 2 beats in flight, pulse rst_n low between clock edges -> out_valid=0 immediately. No stale result after release; in_ready=1.
- Parameter sweep WIDTH=1,8,64 and STAGES=1,4:
  - op=5 (NOR), a=b=0 -> y all ones, all_ones=1
  - parity=WIDTH mod 2
  - latency equals STAGES.
- With LOGIC_UNIT_STATS_EN: 10 output handshakes with random out_ready stalls -> result_count=10. Force the counter to 32'hFFFF_FFFE, then 3 handshakes -> result_count=32'hFFFF_FFFF.
